// File: rtl/mu0_mem_pkg.sv
// Shared types and default constants for the MU0 delay-1 memory subsystem.
// Optional write protection of the low memory region is enabled by defining MU0_MEM_PROTECT_EN.
package mu0_mem_pkg;

    localparam int          ADDR_W_DEF      = 12;
    localparam int          DATA_W_DEF      = 16;
    localparam logic [11:0] OUT_ADDR_DEF    = 12'hFFF;
    localparam logic [11:0] PROTECT_TOP_DEF = 12'h100;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/mu0_ram_sync1.sv
// Single-port RAM with one cycle of registered read latency; a read that coincides
// with a write to the same word returns the word's previous contents.
module mu0_ram_sync1 #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Storage array; deliberately untouched by reset so a program survives a CPU restart.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read data register, holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= {DATA_W{1'b0}};
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mu0_mem_delay1_loader.sv
// MU0 delay-1 memory subsystem: program loader, one-cycle RAM and memory-mapped output register.
// Define MU0_MEM_PROTECT_EN to drop CPU writes below PROTECT_TOP and flag them on prot_err.
module mu0_mem_delay1_loader
    import mu0_mem_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] OUT_ADDR = OUT_ADDR_DEF
`ifdef MU0_MEM_PROTECT_EN
    ,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = PROTECT_TOP_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              cpu_running,
    output logic              cpu_rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              sys_halted,
    output logic              prot_err
);

    state_e            r_state;
    state_e            w_next_state;
    logic              w_load_we;
    logic              w_cpu_we;
    logic              w_prot_hit;
    logic              w_out_hit;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_seen_run;
    logic              r_sys_halted;

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        w_next_state = r_state;
        load_ready   = 1'b0;
        cpu_rst      = 1'b1;
        case (r_state)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_done) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_START: begin
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst      = 1'b0;
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Write-port arbitration: the loader owns the port in LOAD, the CPU in RUN.
    always_comb begin
`ifdef MU0_MEM_PROTECT_EN
        w_prot_hit = (r_state == ST_RUN) && write && (address < PROTECT_TOP);
`else
        w_prot_hit = 1'b0;
`endif
        w_load_we = rst && (r_state == ST_LOAD) && load_valid;
        w_cpu_we  = rst && (r_state == ST_RUN) && write && !w_prot_hit;
        w_out_hit = w_cpu_we && (address == OUT_ADDR);
        w_we      = w_load_we || w_cpu_we;
        if (w_load_we) begin
            w_waddr = load_addr;
            w_wdata = load_data;
        end else begin
            w_waddr = address;
            w_wdata = writedata;
        end
    end

    mu0_ram_sync1 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_re    (read),
        .i_raddr (address),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .o_rdata (readdata)
    );

    // Output register pulse and halt detection (halt needs a running cycle first).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_data   <= {DATA_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_seen_run   <= 1'b0;
            r_sys_halted <= 1'b0;
        end else begin
            r_out_valid <= w_out_hit;
            if (w_out_hit) begin
                r_out_data <= writedata;
            end
            if (r_state == ST_RUN) begin
                if (cpu_running) begin
                    r_seen_run <= 1'b1;
                end else if (r_seen_run) begin
                    r_sys_halted <= 1'b1;
                end
            end
        end
    end

`ifdef MU0_MEM_PROTECT_EN
    logic r_prot_err;

    // Sticky protection violation flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prot_err <= 1'b0;
        end else if (w_prot_hit) begin
            r_prot_err <= 1'b1;
        end
    end

    assign prot_err = r_prot_err;
`else
    assign prot_err = 1'b0;
`endif

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign sys_halted = r_sys_halted;

endmodule

// File: tb/tb_mu0_mem_delay1_loader.sv
// Self-checking bench: a behavioural memory/phase model is compared with the DUT every cycle.
module tb_mu0_mem_delay1_loader;

`ifdef MU0_MEM_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, read, write, cpu_running, load_valid, load_done;
    logic [11:0] address, load_addr;
    logic [15:0] writedata, load_data;
    logic [15:0] readdata, out_data;
    logic        cpu_rst, load_ready, out_valid, sys_halted, prot_err;

    always #5 clk = ~clk;

    mu0_mem_delay1_loader dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .cpu_running(cpu_running),
        .cpu_rst(cpu_rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .out_data(out_data), .out_valid(out_valid), .sys_halted(sys_halted),
        .prot_err(prot_err)
    );

    // Behavioural model: phase 0 = loading, 1 = start cycle, 2 = CPU running.
    logic [15:0] m_mem [4096];
    bit          m_known [4096];
    logic [15:0] m_rd = 16'h0000;
    bit          m_rd_known = 1'b0;
    logic [15:0] m_out = 16'h0000;
    bit          m_ov = 1'b0, m_halt = 1'b0, m_perr = 1'b0, m_seen = 1'b0;
    int          m_phase = 0;
    int          tests = 0, fails = 0;

    logic [11:0] pool [8] = '{12'h003, 12'h005, 12'h010, 12'h0FF, 12'h100, 12'hFFF, 12'h020, 12'h7A0};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_rd = 16'h0000; m_rd_known = 1'b1; m_out = 16'h0000; m_ov = 1'b0;
            m_halt = 1'b0; m_perr = 1'b0; m_seen = 1'b0; m_phase = 0;
        end else begin
            if (read) begin
                m_rd = m_mem[address];
                m_rd_known = m_known[address];
            end
            m_ov = 1'b0;
            if (m_phase == 0 && load_valid) begin
                m_mem[load_addr] = load_data;
                m_known[load_addr] = 1'b1;
            end
            if (m_phase == 2 && write) begin
                if (PROT && address < 12'h100) begin
                    m_perr = 1'b1;
                end else begin
                    m_mem[address] = writedata;
                    m_known[address] = 1'b1;
                    if (address == 12'hFFF) begin
                        m_out = writedata;
                        m_ov = 1'b1;
                    end
                end
            end
            if (m_phase == 2) begin
                if (cpu_running) m_seen = 1'b1;
                else if (m_seen) m_halt = 1'b1;
            end
            if (m_phase == 0) begin
                if (load_done) m_phase = 1;
            end else begin
                m_phase = 2;
            end
        end
    endtask

    task automatic compare();
        if (m_rd_known) check("readdata", readdata, m_rd);
        check("out_data", out_data, m_out);
        check("out_valid", {15'd0, out_valid}, {15'd0, m_ov});
        check("sys_halted", {15'd0, sys_halted}, {15'd0, m_halt});
        check("prot_err", {15'd0, prot_err}, {15'd0, m_perr});
        check("cpu_rst", {15'd0, cpu_rst}, {15'd0, (m_phase != 2)});
        check("load_ready", {15'd0, load_ready}, {15'd0, (m_phase == 0)});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic quiet();
        read = 1'b0; write = 1'b0; load_valid = 1'b0; load_done = 1'b0;
    endtask

    logic [11:0] ld_a [9] = '{12'h000, 12'h001, 12'h002, 12'h005, 12'h010, 12'h0FF, 12'h100, 12'hFFF, 12'h003};
    logic [15:0] ld_d [9] = '{16'h0003, 16'h8000, 16'h7000, 16'h0555, 16'h1111, 16'h00FF, 16'h0100, 16'h0F0F, 16'h002A};

    initial begin
        rst = 1'b0; cpu_running = 1'b0; address = 12'h000; writedata = 16'h0000;
        load_addr = 12'h000; load_data = 16'h0000;
        quiet();
        #2;
        step(); step();
        check("reset_readdata", readdata, 16'h0000);
        check("reset_load_ready", {15'd0, load_ready}, 16'h0001);
        #1 rst = 1'b1;

        // Program load, done flagged with the final word.
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1; load_addr = ld_a[i]; load_data = ld_d[i];
            load_done = (i == 8);
            step();
            #1;
        end
        check("start_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
        check("start_load_ready", {15'd0, load_ready}, 16'h0000);
        quiet();
        step();
        check("run_cpu_rst", {15'd0, cpu_rst}, 16'h0000);
        #1 cpu_running = 1'b1;

        // Read latency and hold.
        read = 1'b1; address = 12'h003;
        #1 check("read_not_early", readdata, 16'h0000);
        step();
        check("read_word3", readdata, 16'h002A);
        #1 read = 1'b0; address = 12'h001;
        step();
        check("read_hold", readdata, 16'h002A);

        // Output register.
        #1 write = 1'b1; address = 12'hFFF; writedata = 16'h1234;
        step();
        check("out_data", out_data, 16'h1234);
        check("out_pulse", {15'd0, out_valid}, 16'h0001);
        #1 write = 1'b0; read = 1'b1;
        step();
        check("out_pulse_end", {15'd0, out_valid}, 16'h0000);
        check("read_out_addr", readdata, 16'h1234);

        // Read during write returns old data.
        #1 write = 1'b1; read = 1'b1; address = 12'h010; writedata = 16'h2222;
        step();
        check("rdw_old", readdata, 16'h1111);
        #1 write = 1'b0;
        step();
        check("rdw_new", readdata, 16'h2222);

        // Low-region write, protected or not depending on build.
        #1 write = 1'b1; read = 1'b0; address = 12'h005; writedata = 16'hBEEF;
        step();
        check("prot_flag", {15'd0, prot_err}, {15'd0, PROT});
        #1 write = 1'b0; read = 1'b1;
        step();
        check("prot_ram", readdata, PROT ? 16'h0555 : 16'hBEEF);
        check("prot_sticky", {15'd0, prot_err}, {15'd0, PROT});

        // Randomized CPU traffic.
        for (int i = 0; i < 300; i++) begin
            #1;
            read = 1'($urandom_range(1)); write = ($urandom_range(2) == 0);
            address = pool[$urandom_range(7)]; writedata = 16'($urandom);
            load_valid = 1'($urandom_range(1)); load_addr = pool[$urandom_range(7)];
            load_data = 16'($urandom); load_done = 1'($urandom_range(1));
            step();
        end
        #1 quiet(); cpu_running = 1'b0;
        step();
        check("halted", {15'd0, sys_halted}, 16'h0001);

        // Reset mid-run keeps RAM.
        #1 rst = 1'b0;
        step();
        #1 rst = 1'b1; read = 1'b1; address = 12'h001;
        step();
        check("rst_load_ready", {15'd0, load_ready}, 16'h0001);
        check("rst_cpu_rst", {15'd0, cpu_rst}, 16'h0001);
        check("rst_halt_clr", {15'd0, sys_halted}, 16'h0000);
        check("ram_kept", readdata, 16'h8000);

        // Randomized reload then run.
        for (int i = 0; i < 120; i++) begin
            #1;
            read = 1'($urandom_range(1)); write = 1'($urandom_range(1));
            address = pool[$urandom_range(7)]; writedata = 16'($urandom);
            load_valid = 1'($urandom_range(1)); load_addr = pool[$urandom_range(7)];
            load_data = 16'($urandom); load_done = (i == 60);
            cpu_running = ($urandom_range(3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
